trap_seq: RTL and testbench

TRAP_SEQ -- requirements
Module: trap_seq

---
 rtl/trap_seq.sv | 149 ++++++++++++++
 tb/tb_trap_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_seq.sv
// Machine-mode trap sequencer: serialises the mepc/mcause/mstatus CSR writes and the
// fetch redirect for traps and mret, and passes software CSR writes through while idle.
module trap_seq #(
    parameter int unsigned          CSR_WIDTH   = 32,
    parameter logic [CSR_WIDTH-1:0] MSTATUS_RST = 32'h1800
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trap_valid,
    input  logic [CSR_WIDTH-1:0] trap_pc,
    input  logic [CSR_WIDTH-1:0] trap_cause,
    input  logic                 mret_valid,
    input  logic                 sw_valid,
    input  logic [3:0]           sw_wen,
    input  logic [CSR_WIDTH-1:0] sw_wdata,
    output logic                 req_ready,
    input  logic [CSR_WIDTH-1:0] mepc_out,
    input  logic [CSR_WIDTH-1:0] mcause_out,
    input  logic [CSR_WIDTH-1:0] mstatus_out,
    input  logic [CSR_WIDTH-1:0] mtvec_out,
    output logic [CSR_WIDTH-1:0] mepc_in,
    output logic [CSR_WIDTH-1:0] mcause_in,
    output logic [CSR_WIDTH-1:0] mstatus_in,
    output logic [CSR_WIDTH-1:0] mtvec_in,
    output logic [3:0]           csr_wen,
    output logic                 redirect_valid,
    output logic [CSR_WIDTH-1:0] redirect_pc,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T_EPC,
        S_T_CAUSE,
        S_T_STATUS,
        S_T_JUMP,
        S_R_STATUS,
        S_R_JUMP
    } state_e;

    // Both trap entry and mret leave MPP at machine mode, the same value reset installs.
    localparam logic [1:0] MPP_M    = MSTATUS_RST[12:11];
    localparam int         MIE_BIT  = 3;
    localparam int         MPIE_BIT = 7;

    state_e               state_q, state_d;
    logic [CSR_WIDTH-1:0] pc_q, pc_d;
    logic [CSR_WIDTH-1:0] cause_q, cause_d;

    // mcause is write-only here; mtvec MODE bits and the low pc bits are discarded.
    logic unused_ok;
    assign unused_ok = ^{mcause_out, mtvec_out[1:0], pc_q[1:0]};

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        case (state_q)
            S_IDLE: begin
                if (trap_valid) begin
                    state_d = S_T_EPC;
                    pc_d    = trap_pc;
                    cause_d = trap_cause;
                end else if (mret_valid) begin
                    state_d = S_R_STATUS;
                end
            end
            S_T_EPC:    state_d = S_T_CAUSE;
            S_T_CAUSE:  state_d = S_T_STATUS;
            S_T_STATUS: state_d = S_T_JUMP;
            S_R_STATUS: state_d = S_R_JUMP;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is high, even if the old state is mid-sequence.
    always_comb begin
        csr_wen        = 4'b0000;
        mepc_in        = '0;
        mcause_in      = '0;
        mstatus_in     = '0;
        mtvec_in       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (sw_valid && !trap_valid && !mret_valid && (sw_wen != 4'b0000)) begin
                        csr_wen    = sw_wen;
                        mepc_in    = sw_wdata;
                        mcause_in  = sw_wdata;
                        mstatus_in = sw_wdata;
                        mtvec_in   = sw_wdata;
                    end
                end
                S_T_EPC: begin
                    csr_wen = 4'b0001;
                    mepc_in = {pc_q[CSR_WIDTH-1:2], 2'b00};
                end
                S_T_CAUSE: begin
                    csr_wen   = 4'b0010;
                    mcause_in = cause_q;
                end
                S_T_STATUS: begin
                    csr_wen               = 4'b0100;
                    mstatus_in            = mstatus_out;
                    mstatus_in[MPIE_BIT]  = mstatus_out[MIE_BIT];
                    mstatus_in[MIE_BIT]   = 1'b0;
                    mstatus_in[12:11]     = MPP_M;
                end
                S_T_JUMP: begin
                    redirect_valid = 1'b1;
                    redirect_pc    = {mtvec_out[CSR_WIDTH-1:2], 2'b00};
                end
                S_R_STATUS: begin
                    csr_wen               = 4'b0100;
                    mstatus_in            = mstatus_out;
                    mstatus_in[MIE_BIT]   = mstatus_out[MPIE_BIT];
                    mstatus_in[MPIE_BIT]  = 1'b1;
                    mstatus_in[12:11]     = MPP_M;
                end
                S_R_JUMP: begin
                    redirect_valid = 1'b1;
                    redirect_pc    = mepc_out;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = !rst && (state_q == S_IDLE);
    assign busy      = !rst && (state_q != S_IDLE);

endmodule

// File: tb/tb_trap_seq.sv
// Self-checking bench for trap_seq: directed scenarios followed by random traffic,
// all compared against a schedule-of-expected-cycles reference model.
module tb_trap_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_valid, mret_valid, sw_valid;
    logic [31:0] trap_pc, trap_cause, sw_wdata;
    logic [3:0]  sw_wen;
    logic        req_ready;
    logic [31:0] mepc_out, mcause_out, mstatus_out, mtvec_out;
    logic [31:0] mepc_in, mcause_in, mstatus_in, mtvec_in;
    logic [3:0]  csr_wen;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    trap_seq dut (
        .clk            (clk),
        .rst            (rst),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .trap_cause     (trap_cause),
        .mret_valid     (mret_valid),
        .sw_valid       (sw_valid),
        .sw_wen         (sw_wen),
        .sw_wdata       (sw_wdata),
        .req_ready      (req_ready),
        .mepc_out       (mepc_out),
        .mcause_out     (mcause_out),
        .mstatus_out    (mstatus_out),
        .mtvec_out      (mtvec_out),
        .mepc_in        (mepc_in),
        .mcause_in      (mcause_in),
        .mstatus_in     (mstatus_in),
        .mtvec_in       (mtvec_in),
        .csr_wen        (csr_wen),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // One entry per future busy cycle: what the CSR/redirect outputs must show then.
    typedef struct packed {
        logic [3:0]  wen;
        logic [31:0] epc;
        logic [31:0] cause;
        logic [31:0] status;
        logic [31:0] tvec;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    exp_t sched[$];

    function automatic logic [31:0] trap_status(input logic [31:0] m);
        return (m & ~32'h0000_1888) | 32'h0000_1800 | ((m & 32'h8) << 4);
    endfunction

    function automatic logic [31:0] mret_status(input logic [31:0] m);
        return (m & ~32'h0000_1888) | 32'h0000_1880 | ((m & 32'h80) >> 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Compare every output against the model for this cycle, then advance the model.
    task automatic sample();
        exp_t e;
        exp_t r;
        logic exp_ready;
        logic exp_busy;
        @(negedge clk);
        e = '0;
        if (rst) begin
            exp_ready = 1'b0;
            exp_busy  = 1'b0;
        end else if (sched.size() != 0) begin
            e         = sched[0];
            exp_ready = 1'b0;
            exp_busy  = 1'b1;
        end else begin
            exp_ready = 1'b1;
            exp_busy  = 1'b0;
            if (sw_valid && !trap_valid && !mret_valid && sw_wen != 4'b0000) begin
                e.wen    = sw_wen;
                e.epc    = sw_wdata;
                e.cause  = sw_wdata;
                e.status = sw_wdata;
                e.tvec   = sw_wdata;
            end
        end
        check("csr_wen",        {28'b0, csr_wen},        {28'b0, e.wen});
        check("mepc_in",        mepc_in,                 e.epc);
        check("mcause_in",      mcause_in,               e.cause);
        check("mstatus_in",     mstatus_in,              e.status);
        check("mtvec_in",       mtvec_in,                e.tvec);
        check("redirect_valid", {31'b0, redirect_valid}, {31'b0, e.redir});
        check("redirect_pc",    redirect_pc,             e.rpc);
        check("req_ready",      {31'b0, req_ready},      {31'b0, exp_ready});
        check("busy",           {31'b0, busy},           {31'b0, exp_busy});

        if (rst) begin
            sched.delete();
        end else if (sched.size() != 0) begin
            void'(sched.pop_front());
        end else if (trap_valid) begin
            r = '0; r.wen = 4'b0001; r.epc = trap_pc & ~32'h3;                sched.push_back(r);
            r = '0; r.wen = 4'b0010; r.cause = trap_cause;                    sched.push_back(r);
            r = '0; r.wen = 4'b0100; r.status = trap_status(mstatus_out);     sched.push_back(r);
            r = '0; r.redir = 1'b1;  r.rpc = mtvec_out & ~32'h3;              sched.push_back(r);
        end else if (mret_valid) begin
            r = '0; r.wen = 4'b0100; r.status = mret_status(mstatus_out);     sched.push_back(r);
            r = '0; r.redir = 1'b1;  r.rpc = mepc_out;                        sched.push_back(r);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        trap_valid = 1'b0; mret_valid = 1'b0; sw_valid = 1'b0;
        trap_pc = '0; trap_cause = '0; sw_wen = '0; sw_wdata = '0;
        mepc_out = '0; mcause_out = '0; mstatus_out = 32'h1800; mtvec_out = '0;

        // Reset: everything quiet, req_ready low while rst is high.
        step();
        sample();
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        tick();
        rst = 1'b0;
        sample();
        check("post_rst_ready", {31'b0, req_ready}, 32'd1);
        tick();

        // Software write to mtvec, then a multi-bit write.
        sw_valid = 1'b1; sw_wen = 4'b1000; sw_wdata = 32'h8000_0000;
        sample();
        check("sw_mtvec_wen", {28'b0, csr_wen}, 32'h8);
        check("sw_mtvec_in",  mtvec_in,         32'h8000_0000);
        check("sw_busy",      {31'b0, busy},    32'd0);
        tick();
        sw_wen = 4'b0101; sw_wdata = 32'hAAAA_5555;
        sample();
        check("sw_multi_wen", {28'b0, csr_wen}, 32'h5);
        check("sw_multi_st",  mstatus_in,       32'hAAAA_5555);
        tick();
        sw_valid = 1'b0;
        step();

        // Trap with known CSR values.
        mstatus_out = 32'h1808; mtvec_out = 32'h8000_0101;
        trap_valid = 1'b1; trap_pc = 32'h8000_0046; trap_cause = 32'd11;
        step();
        trap_valid = 1'b0;
        sample(); check("trap_mepc",    mepc_in,     32'h8000_0044); tick();
        sample(); check("trap_mcause",  mcause_in,   32'd11);        tick();
        sample(); check("trap_mstatus", mstatus_in,  32'h1880);      tick();
        sample(); check("trap_rpc",     redirect_pc, 32'h8000_0100); tick();
        sample(); check("trap_ready",   {31'b0, req_ready}, 32'd1);  tick();

        // Mret with known CSR values.
        mstatus_out = 32'h1880; mepc_out = 32'h8000_0048;
        mret_valid = 1'b1;
        step();
        mret_valid = 1'b0;
        sample(); check("mret_mstatus", mstatus_in,  32'h1888);      tick();
        sample(); check("mret_rpc",     redirect_pc, 32'h8000_0048); tick();
        step();

        // All three requests at once; mret and sw held until each is accepted.
        mstatus_out = 32'h1808; mtvec_out = 32'h0000_0200;
        trap_valid = 1'b1; trap_pc = 32'h0000_2002; trap_cause = 32'd2;
        mret_valid = 1'b1; sw_valid = 1'b1; sw_wen = 4'b0001; sw_wdata = 32'h1234_5678;
        sample(); check("pri_acc_wen", {28'b0, csr_wen}, 32'h0); tick();
        trap_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            sample();
            check("pri_ready_low", {31'b0, req_ready}, 32'd0);
            tick();
        end
        sample();
        check("pri_mret_ready", {31'b0, req_ready}, 32'd1);
        check("pri_sw_blocked", {28'b0, csr_wen},   32'h0);
        tick();
        mret_valid = 1'b0;
        sample(); check("pri_r_status", {28'b0, csr_wen}, 32'h4); tick();
        sample(); check("pri_r_jump", {31'b0, redirect_valid}, 32'd1); tick();
        sample();
        check("held_sw_wen",  {28'b0, csr_wen}, 32'h1);
        check("held_sw_mepc", mepc_in,          32'h1234_5678);
        tick();
        sw_valid = 1'b0;
        sample(); check("held_sw_once", {28'b0, csr_wen}, 32'h0); tick();

        // Reset in T_CAUSE aborts the trap; a later trap completes.
        trap_valid = 1'b1; trap_pc = 32'h0000_0100; trap_cause = 32'd3;
        step();
        trap_valid = 1'b0;
        step();
        rst = 1'b1;
        sample(); check("abort_wen", {28'b0, csr_wen}, 32'h0); tick();
        rst = 1'b0;
        sample();
        check("abort_idle_ready", {31'b0, req_ready},      32'd1);
        check("abort_no_redir",   {31'b0, redirect_valid}, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) step();
        trap_valid = 1'b1; trap_pc = 32'h0000_0300; trap_cause = 32'd7;
        step();
        trap_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Random traffic; CSR inputs only change while the model is idle.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (sched.size() == 0) begin
                mstatus_out = $urandom; mtvec_out = $urandom;
                mepc_out    = $urandom; mcause_out = $urandom;
            end
            trap_valid = ($urandom_range(0, 4) == 0);
            mret_valid = ($urandom_range(0, 3) == 0);
            sw_valid   = ($urandom_range(0, 2) == 0);
            trap_pc    = $urandom;
            trap_cause = $urandom;
            sw_wen     = 4'($urandom);
            sw_wdata   = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
